mem_access_ctrl: RTL and testbench

Memory-stage data-bus controller. It accepts one load or store per transaction from the pipeline and checks alignment. It builds byte-lane write data, strobe and size, sequences the two-phase dbus handshake (addr_ok, then data_ok) and stalls the pipeline until the access finishes. For loads it extracts and sign- or zero-extends the returned data. It sits between the memory pipeline stage and the dbus port.

---
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Data-bus (dbus) port bundle between the memory-stage controller and memory.
//   dreq_valid    request valid (controller -> memory)
//   dreq_addr     byte address of the access
//   dreq_size     access size code: 0=1B, 1=2B, 2=4B, 3=8B
//   dreq_strobe   byte-lane write enables, zero for loads
//   dreq_data     lane-aligned store data
//   dresp_addr_ok address phase accepted (memory -> controller)
//   dresp_data_ok data phase complete
//   dresp_data    lane-aligned read data
// master: the controller side; slave: the memory side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [1:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [DW-1:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage data-bus controller. Accepts one load/store from the pipeline,
// checks alignment, builds lane-aligned write data and strobes, runs the
// two-phase dbus handshake (addr_ok then data_ok), stalls the pipeline while
// the access is outstanding and returns sign/zero-extended load data.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   valid         memory op present (fields held while stall=1)
//   is_store      1=store, 0=load
//   addr          byte address
//   wdata         right-justified store data
//   msize         0=1B, 1=2B, 2=4B, 3=8B
//   load_signed   sign-extend the load result
//   flush         kill the current op
//   dbus          dbus master port (see mem_access_ctrl_if)
//   stall         hold the pipeline
//   done          one-cycle completion pulse
//   rdata         extended load result, valid with done (0 for stores)
//   misalign      with done: access faulted, no bus traffic issued
// -----------------------------------------------------------------------------

// Protocol checker for the controller's dbus handshake.
module mem_access_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic in_req,
  input logic dreq_valid,
  input logic done,
  input logic addr_ok,
  input logic data_ok
);
  // The data phase may not complete before the address phase is accepted.
  a_data_before_addr: assert property (@(posedge clk) disable iff (reset)
    !(in_req && data_ok && !addr_ok));

  // A completion pulse never coincides with an outstanding request.
  a_no_req_with_done: assert property (@(posedge clk) disable iff (reset)
    !(dreq_valid && done));
endmodule

module mem_access_ctrl #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 is_store,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wdata,
  input  logic [1:0]           msize,
  input  logic                 load_signed,
  input  logic                 flush,
  mem_access_ctrl_if.master    dbus,
  output logic                 stall,
  output logic                 done,
  output logic [DW-1:0]        rdata,
  output logic                 misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e        state_r;
  logic          dreq_valid_r;
  logic [AW-1:0] dreq_addr_r;
  logic [1:0]    dreq_size_r;
  logic [7:0]    dreq_strobe_r;
  logic [63:0]   dreq_data_r;
  logic          done_r;
  logic          misalign_r;
  logic [63:0]   rdata_r;
  logic          killed_r;
  logic          op_store_r;
  logic          op_signed_r;

  logic          busy_s;
  logic          kill_now_s;
  logic          in_req_s;
  logic [63:0]   load_result_s;

  // Alignment fault: the low address bits must be zero for the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic res;
    case (size)
      2'd0:    res = 1'b0;
      2'd1:    res = off[0];
      2'd2:    res = |off[1:0];
      2'd3:    res = |off;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Byte enables: 2^size ones shifted to the starting lane.
  function automatic logic [7:0] lane_strobe(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      2'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Move right-justified store data onto its byte lanes.
  function automatic logic [63:0] lane_data(input logic [63:0] data, input logic [2:0] off);
    return data << {off, 3'b000};
  endfunction

  // Pull the addressed bytes down to bit 0 and extend them to 64 bits.
  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [2:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [63:0] raw;
    logic [63:0] res;
    raw = data >> {off, 3'b000};
    case (size)
      2'd0:    res = {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    res = {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    res = {{32{sgn & raw[31]}}, raw[31:0]};
      2'd3:    res = raw;
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Status decode and the value captured into rdata on completion.
  always_comb begin
    busy_s     = (state_r == ST_REQ) || (state_r == ST_WAIT);
    in_req_s   = (state_r == ST_REQ);
    kill_now_s = killed_r | flush;
    if (op_store_r) begin
      load_result_s = 64'd0;
    end else begin
      load_result_s = load_extend(dbus.dresp_data, dreq_addr_r[2:0], dreq_size_r, op_signed_r);
    end
  end

  // A flushed op no longer holds the pipeline, even while its bus access drains.
  assign stall = valid & ~done_r & ~(busy_s & kill_now_s);

  // Access sequencer: accept, request, wait for data, report completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      dreq_valid_r  <= 1'b0;
      dreq_addr_r   <= '0;
      dreq_size_r   <= 2'd0;
      dreq_strobe_r <= 8'h00;
      dreq_data_r   <= 64'd0;
      done_r        <= 1'b0;
      misalign_r    <= 1'b0;
      rdata_r       <= 64'd0;
      killed_r      <= 1'b0;
      op_store_r    <= 1'b0;
      op_signed_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
          killed_r   <= 1'b0;
          if (valid && !flush) begin
            dreq_addr_r   <= addr;
            dreq_size_r   <= msize;
            op_store_r    <= is_store;
            op_signed_r   <= load_signed;
            dreq_strobe_r <= is_store ? lane_strobe(addr[2:0], msize) : 8'h00;
            dreq_data_r   <= is_store ? lane_data(wdata, addr[2:0]) : 64'd0;
            if (is_misaligned(addr[2:0], msize)) begin
              // Fault reported straight away; the bus is never touched.
              state_r      <= ST_DONE;
              done_r       <= 1'b1;
              misalign_r   <= 1'b1;
              rdata_r      <= 64'd0;
              dreq_valid_r <= 1'b0;
            end else begin
              state_r      <= ST_REQ;
              dreq_valid_r <= 1'b1;
            end
          end else begin
            state_r      <= ST_IDLE;
            dreq_valid_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (flush) begin
            killed_r <= 1'b1;
          end
          if (dbus.dresp_addr_ok) begin
            dreq_valid_r <= 1'b0;
            if (dbus.dresp_data_ok) begin
              if (kill_now_s) begin
                state_r  <= ST_IDLE;
                killed_r <= 1'b0;
              end else begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
                rdata_r <= load_result_s;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            killed_r <= 1'b1;
          end
          if (dbus.dresp_data_ok) begin
            if (kill_now_s) begin
              state_r  <= ST_IDLE;
              killed_r <= 1'b0;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              rdata_r <= load_result_s;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          dreq_valid_r <= 1'b0;
          done_r       <= 1'b0;
          misalign_r   <= 1'b0;
          killed_r     <= 1'b0;
        end
      endcase
    end
  end

  assign dbus.dreq_valid  = dreq_valid_r;
  assign dbus.dreq_addr   = dreq_addr_r;
  assign dbus.dreq_size   = dreq_size_r;
  assign dbus.dreq_strobe = dreq_strobe_r;
  assign dbus.dreq_data   = dreq_data_r;
  assign done             = done_r;
  assign misalign         = misalign_r;
  assign rdata            = rdata_r;

  mem_access_ctrl_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .in_req     (in_req_s),
    .dreq_valid (dreq_valid_r),
    .done       (done_r),
    .addr_ok    (dbus.dresp_addr_ok),
    .data_ok    (dbus.dresp_data_ok)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases followed by random
// loads/stores with random bus latencies and flushes, checked against a
// transaction-level model of the expected outputs and their timing.
module tb_mem_access_ctrl;
  logic        clk;
  logic        reset;
  logic        valid;
  logic        is_store;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  msize;
  logic        load_signed;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] rdata;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl_if #(.AW(64), .DW(64)) dbus_if ();

  mem_access_ctrl #(.AW(64), .DW(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .is_store    (is_store),
    .addr        (addr),
    .wdata       (wdata),
    .msize       (msize),
    .load_signed (load_signed),
    .flush       (flush),
    .dbus        (dbus_if),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] exp_rdata(input logic [63:0] d, input int off, input int sz, input bit sg);
    int nb;
    logic [63:0] raw, mask, v;
    nb  = 1 << sz;
    raw = d >> (8 * off);
    if (nb == 8) return raw;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = raw & mask;
    if (sg && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] exp_strobe(input int off, input int sz);
    logic [15:0] s;
    s = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return s[7:0];
  endfunction

  function automatic bit exp_misaligned(input logic [63:0] a, input int sz);
    return (a % (64'd1 << sz)) != 64'd0;
  endfunction

  // Advance to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_quiet();
    dbus_if.dresp_addr_ok = 1'b0;
    dbus_if.dresp_data_ok = 1'b0;
    dbus_if.dresp_data    = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dreq_valid"}, 64'(dbus_if.dreq_valid), 64'd0);
    check_eq({tag, "_dreq_addr"}, dbus_if.dreq_addr, 64'd0);
    check_eq({tag, "_dreq_size"}, 64'(dbus_if.dreq_size), 64'd0);
    check_eq({tag, "_dreq_strobe"}, 64'(dbus_if.dreq_strobe), 64'd0);
    check_eq({tag, "_dreq_data"}, dbus_if.dreq_data, 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_misalign"}, 64'(misalign), 64'd0);
    check_eq({tag, "_rdata"}, rdata, 64'd0);
  endtask

  // One memory op. Starts in the current cycle (controller idle) and returns
  // in the first cycle in which the next op may be offered.
  // ad: extra cycles before addr_ok; dd: cycles from addr_ok to data_ok (0 = same cycle).
  // fmode: 0 none, 1 flush at cycle fat while busy, 2 flush in the done cycle.
  task automatic run_op(input bit st, input logic [63:0] a, input logic [63:0] wd, input int sz,
                        input bit sg, input int ad, input int dd, input int fmode, input int fat);
    int          off;
    int          dcyc;
    bit          killed;
    bit          kill_here;
    logic [63:0] rd_seen;
    off     = int'(a[2:0]);
    dcyc    = 1 + ad + dd;
    killed  = 1'b0;
    rd_seen = 64'd0;
    valid = 1'b1; is_store = st; addr = a; wdata = wd; msize = 2'(sz);
    load_signed = sg; flush = 1'b0;
    bus_quiet();
    #1;
    check_eq("stall_accept", 64'(stall), 64'd1);
    check_eq("done_accept", 64'(done), 64'd0);
    if (exp_misaligned(a, sz)) begin
      next_cycle();
      bus_quiet();
      #1;
      check_eq("mis_done", 64'(done), 64'd1);
      check_eq("mis_flag", 64'(misalign), 64'd1);
      check_eq("mis_dreq_valid", 64'(dbus_if.dreq_valid), 64'd0);
      check_eq("mis_stall", 64'(stall), 64'd0);
      next_cycle();
      valid = 1'b0;
      #1;
      check_eq("mis_done_pulse", 64'(done), 64'd0);
      check_eq("mis_dreq_valid2", 64'(dbus_if.dreq_valid), 64'd0);
      return;
    end
    for (int c = 1; c <= dcyc + 1; c++) begin
      next_cycle();
      if (killed) valid = 1'b0;
      kill_here = (fmode == 1) && (c == fat);
      flush = kill_here || ((fmode == 2) && (c == dcyc + 1));
      dbus_if.dresp_addr_ok = (c == 1 + ad);
      dbus_if.dresp_data_ok = (c == dcyc);
      dbus_if.dresp_data    = {$urandom, $urandom};
      if (c == dcyc) rd_seen = dbus_if.dresp_data;
      #1;
      if (c <= dcyc) begin
        check_eq("dreq_valid", 64'(dbus_if.dreq_valid), 64'(c <= 1 + ad));
        if (c <= 1 + ad) begin
          check_eq("dreq_addr", dbus_if.dreq_addr, a);
          check_eq("dreq_size", 64'(dbus_if.dreq_size), 64'(sz));
          check_eq("dreq_strobe", 64'(dbus_if.dreq_strobe), st ? 64'(exp_strobe(off, sz)) : 64'd0);
          check_eq("dreq_data", dbus_if.dreq_data, st ? (wd << (8 * off)) : 64'd0);
        end
        check_eq("done_busy", 64'(done), 64'd0);
        check_eq("stall_busy", 64'(stall), 64'(!(killed || kill_here)));
      end else begin
        check_eq("dreq_valid_end", 64'(dbus_if.dreq_valid), 64'd0);
        check_eq("done_end", 64'(done), 64'(!killed));
        if (!killed) begin
          check_eq("misalign_end", 64'(misalign), 64'd0);
          check_eq("rdata", rdata, st ? 64'd0 : exp_rdata(rd_seen, off, sz, sg));
          check_eq("stall_done", 64'(stall), 64'd0);
        end
      end
      if (kill_here) killed = 1'b1;
    end
    flush = 1'b0;
    if (killed) return;
    next_cycle();
    valid = 1'b0;
    bus_quiet();
    #1;
    check_eq("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      valid = 1'b0;
      flush = 1'($urandom_range(0, 1));
      bus_quiet();
      #1;
      check_eq("idle_done", 64'(done), 64'd0);
      check_eq("idle_dreq_valid", 64'(dbus_if.dreq_valid), 64'd0);
    end
    flush = 1'b0;
  endtask

  task automatic flush_idle();
    valid = 1'b1; is_store = 1'b0; addr = 64'h4000; msize = 2'd3; flush = 1'b1;
    bus_quiet();
    next_cycle();
    valid = 1'b0; flush = 1'b0;
    #1;
    check_eq("fidle_dreq_valid", 64'(dbus_if.dreq_valid), 64'd0);
    check_eq("fidle_done", 64'(done), 64'd0);
    next_cycle();
    #1;
    check_eq("fidle_dreq_valid2", 64'(dbus_if.dreq_valid), 64'd0);
  endtask

  task automatic reset_mid_req();
    valid = 1'b1; is_store = 1'b1; addr = 64'h5008; wdata = 64'h1122; msize = 2'd1;
    load_signed = 1'b0; flush = 1'b0;
    bus_quiet();
    next_cycle();
    #1;
    check_eq("rst_req_dreq_valid", 64'(dbus_if.dreq_valid), 64'd1);
    reset = 1'b1;
    valid = 1'b0;
    next_cycle();
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    next_cycle();
    check_eq("rst_after_dreq_valid", 64'(dbus_if.dreq_valid), 64'd0);
  endtask

  initial begin
    bit          st, sg;
    int          sz, ad, dd, fm, fat, r;
    logic [63:0] a;
    reset = 1'b1; valid = 1'b0; is_store = 1'b0; addr = 64'd0; wdata = 64'd0;
    msize = 2'd0; load_signed = 1'b0; flush = 1'b0;
    bus_quiet();
    repeat (3) next_cycle();
    check_reset_outputs("reset");
    reset = 1'b0;
    next_cycle();

    // Directed cases.
    run_op(1'b1, 64'h1003, 64'hAB, 0, 1'b0, 0, 0, 0, 0);
    dbus_if.dresp_data = 64'h8001_0000_0000_0000;
    run_op(1'b0, 64'h2006, 64'd0, 1, 1'b1, 0, 3, 0, 0);
    run_op(1'b0, 64'h3002, 64'd0, 2, 1'b0, 0, 0, 0, 0);
    run_op(1'b1, 64'h6010, 64'hDEAD_BEEF_0BAD_F00D, 3, 1'b0, 3, 1, 0, 0);
    run_op(1'b0, 64'h7004, 64'd0, 2, 1'b0, 0, 2, 1, 2);
    run_op(1'b0, 64'h7105, 64'd0, 0, 1'b1, 0, 0, 0, 0);
    run_op(1'b0, 64'h7200, 64'd0, 3, 1'b0, 1, 0, 2, 0);
    flush_idle();
    reset_mid_req();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 3);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      ad = $urandom_range(0, 4);
      dd = $urandom_range(0, 4);
      r  = $urandom_range(0, 9);
      fm = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      fat = $urandom_range(1, 1 + ad + dd);
      run_op(st, a, {$urandom, $urandom}, sz, sg, ad, dd, fm, fat);
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
